// File: rtl/latched_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------------------------
// latched_mux_scan_ctrl
//
// Sequencer for a latched input mux. Walks the enabled channels round-robin, issuing a one-cycle
// sel/clken load per channel. It waits MUX_LATENCY-1 settle cycles, then flags dwell_q
// consecutive mux samples as valid data of that channel. At the end of a full sweep it pulses
// sweep_done. It then either returns to idle (single sweep) or starts the next sweep
// (continuous).
//
// Ports
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   start        in   pulse, begin a scan (sampled in idle only)
//   stop         in   pulse, abort a scan
//   mode         in   0 = single sweep, 1 = continuous
//   chan_mask    in   bit i set -> channel i is part of the scan
//   dwell        in   valid samples per channel, 0 is treated as 1
//   manual_sel   in   channel for a manual load
//   manual_load  in   pulse, load manual_sel into the mux (idle only)
//   sel          out  mux channel select
//   clken        out  mux load enable
//   busy         out  high in every state except idle
//   data_valid   out  mux output is settled data of the current channel
//   sweep_done   out  one-cycle pulse on the last valid sample of a sweep
//   err          out  one-cycle pulse when start arrives with an empty mask
//   chan_tag     out  channel of the data flagged by data_valid
//                     (present only when LATCHED_MUX_SCAN_TAG_EN is defined)
//
// Optional feature: define LATCHED_MUX_SCAN_TAG_EN to add the chan_tag output.
// Every output is a flop. Each output's next value is decoded from the next FSM state, so
// the outputs line up with the state they describe.
// ---------------------------------------------------------------------------------------------
module latched_mux_scan_ctrl #(
    parameter int unsigned N_INPUTS    = 3,
    parameter int unsigned SEL_WIDTH   = 2,
    parameter int unsigned DWELL_WIDTH = 16,
    parameter int unsigned MUX_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode,
    input  logic [N_INPUTS-1:0]    chan_mask,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic [SEL_WIDTH-1:0]   manual_sel,
    input  logic                   manual_load,
    output logic [SEL_WIDTH-1:0]   sel,
    output logic                   clken,
    output logic                   busy,
    output logic                   data_valid,
    output logic                   sweep_done,
`ifdef LATCHED_MUX_SCAN_TAG_EN
    output logic                   err,
    output logic [SEL_WIDTH-1:0]   chan_tag
`else
    output logic                   err
`endif
);

    // Wide enough to hold MUX_LATENCY-1 for any MUX_LATENCY >= 1.
    localparam int unsigned SETTLE_W = (MUX_LATENCY > 1) ? $clog2(MUX_LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSwitch = 2'd1,
        StSettle = 2'd2,
        StDwell  = 2'd3
    } state_e;

    // Lowest set bit of the mask. Scanning downwards leaves the smallest index.
    function automatic logic [SEL_WIDTH-1:0] lowest_ch(input logic [N_INPUTS-1:0] m);
        lowest_ch = '0;
        for (int i = int'(N_INPUTS) - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_ch = SEL_WIDTH'(i);
            end
        end
    endfunction

    // Next set bit strictly above cur, wrapping to the lowest set bit.
    function automatic logic [SEL_WIDTH-1:0] next_ch(input logic [N_INPUTS-1:0] m,
                                                     input logic [SEL_WIDTH-1:0] cur);
        next_ch = lowest_ch(m);
        for (int i = int'(N_INPUTS) - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) begin
                next_ch = SEL_WIDTH'(i);
            end
        end
    endfunction

    state_e                 state_q, state_d;
    logic [N_INPUTS-1:0]    mask_q, mask_d;
    logic                   mode_q, mode_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [SEL_WIDTH-1:0]   ch_q, ch_d;

    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                   clken_q, clken_d;
    logic                   busy_q, busy_d;
    logic                   data_valid_q, data_valid_d;
    logic                   sweep_done_q, sweep_done_d;
    logic                   err_q, err_d;

    logic                   manual_ok;
    logic                   wrap_cur;
    logic                   wrap_nxt;

    // manual_sel may encode channels that do not exist when N_INPUTS < 2**SEL_WIDTH.
    assign manual_ok = (32'(manual_sel) < N_INPUTS);

    // The current channel is the last one of the sweep when its successor does not lie above it.
    // This also covers a mask with a single bit set.
    assign wrap_cur = (next_ch(mask_q, ch_q) <= ch_q);
    assign wrap_nxt = (next_ch(mask_d, ch_d) <= ch_d);

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        mode_d       = mode_q;
        dwell_d      = dwell_q;
        cnt_d        = cnt_q;
        settle_d     = settle_q;
        ch_d         = ch_q;
        sel_d        = sel_q;
        clken_d      = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    if (chan_mask != '0) begin
                        mask_d  = chan_mask;
                        mode_d  = mode;
                        dwell_d = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
                        ch_d    = lowest_ch(chan_mask);
                        state_d = StSwitch;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (manual_load && !start && manual_ok) begin
                    sel_d   = manual_sel;
                    clken_d = 1'b1;
                end
            end
            StSwitch: begin
                if (MUX_LATENCY == 1) begin
                    cnt_d   = dwell_q;
                    state_d = StDwell;
                end else begin
                    settle_d = SETTLE_W'(MUX_LATENCY - 1);
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q <= SETTLE_W'(1)) begin
                    cnt_d   = dwell_q;
                    state_d = StDwell;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            StDwell: begin
                if (cnt_q <= DWELL_WIDTH'(1)) begin
                    ch_d    = next_ch(mask_q, ch_q);
                    state_d = (wrap_cur && !mode_q) ? StIdle : StSwitch;
                end else begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over every transition taken above. The sel value is left untouched.
        if (stop && (state_q != StIdle)) begin
            state_d = StIdle;
        end

        // Registered outputs, decoded from the state the FSM enters next.
        if (state_d == StSwitch) begin
            sel_d   = ch_d;
            clken_d = 1'b1;
        end
        busy_d       = (state_d != StIdle);
        data_valid_d = (state_d == StDwell);
        // cnt_d == 1 marks the last dwell cycle. ch does not move while in dwell.
        sweep_done_d = (state_d == StDwell) && (cnt_d == DWELL_WIDTH'(1)) && wrap_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            mode_q       <= 1'b0;
            dwell_q      <= DWELL_WIDTH'(1);
            cnt_q        <= '0;
            settle_q     <= '0;
            ch_q         <= '0;
            sel_q        <= '0;
            clken_q      <= 1'b0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            sweep_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            dwell_q      <= dwell_d;
            cnt_q        <= cnt_d;
            settle_q     <= settle_d;
            ch_q         <= ch_d;
            sel_q        <= sel_d;
            clken_q      <= clken_d;
            busy_q       <= busy_d;
            data_valid_q <= data_valid_d;
            sweep_done_q <= sweep_done_d;
            err_q        <= err_d;
        end
    end

    assign sel        = sel_q;
    assign clken      = clken_q;
    assign busy       = busy_q;
    assign data_valid = data_valid_q;
    assign sweep_done = sweep_done_q;
    assign err        = err_q;

`ifdef LATCHED_MUX_SCAN_TAG_EN
    logic [SEL_WIDTH-1:0] chan_tag_q, chan_tag_d;

    // Captured on the first dwell cycle of each channel and held until the next one.
    always_comb begin
        chan_tag_d = chan_tag_q;
        if ((state_d == StDwell) && (state_q != StDwell)) begin
            chan_tag_d = ch_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chan_tag_q <= '0;
        end else begin
            chan_tag_q <= chan_tag_d;
        end
    end

    assign chan_tag = chan_tag_q;
`endif

endmodule

// File: tb/tb_latched_mux_scan_ctrl.sv
// Directed-vector bench for latched_mux_scan_ctrl (N_INPUTS=3, SEL_WIDTH=2, MUX_LATENCY=2).
// Each vector applies its inputs for one clock cycle. The registered outputs are then compared
// 1 ns after the rising edge.
module tb_latched_mux_scan_ctrl;

    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start, stop, mode, manual_load;
    logic [2:0]  chan_mask;
    logic [15:0] dwell;
    logic [1:0]  manual_sel;
    logic [1:0]  sel;
    logic        clken, busy, data_valid, sweep_done, err;
`ifdef LATCHED_MUX_SCAN_TAG_EN
    logic [1:0]  chan_tag;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    latched_mux_scan_ctrl #(
        .N_INPUTS   (3),
        .SEL_WIDTH  (2),
        .DWELL_WIDTH(16),
        .MUX_LATENCY(ML)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .chan_mask  (chan_mask),
        .dwell      (dwell),
        .manual_sel (manual_sel),
        .manual_load(manual_load),
        .sel        (sel),
        .clken      (clken),
        .busy       (busy),
        .data_valid (data_valid),
        .sweep_done (sweep_done),
`ifdef LATCHED_MUX_SCAN_TAG_EN
        .err        (err),
        .chan_tag   (chan_tag)
`else
        .err        (err)
`endif
    );

    typedef struct {
        bit        start, stop, mode, ld;
        bit [2:0]  mask;
        bit [15:0] dwell;
        bit [1:0]  msel;
        bit [1:0]  e_sel;
        bit        e_ck, e_bs, e_dv, e_sd, e_er;
    } vec_t;

    vec_t vec_a[$];
    vec_t vec_b[$];

    function automatic vec_t mk(int st, int sp, int md, int mask, int dw, int ld, int ms,
                                int es, int ec, int eb, int ed, int esd, int ee);
        vec_t r;
        r.start = st[0];  r.stop = sp[0];  r.mode = md[0];  r.ld = ld[0];
        r.mask  = 3'(mask);  r.dwell = 16'(dw);  r.msel = 2'(ms);
        r.e_sel = 2'(es);  r.e_ck = ec[0];  r.e_bs = eb[0];
        r.e_dv  = ed[0];  r.e_sd = esd[0];  r.e_er = ee[0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; mode = 0; manual_load = 0;
        chan_mask = 0; dwell = 0; manual_sel = 0;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " sel"},        32'(sel),        32'(v.e_sel));
        chk({tag, " clken"},      32'(clken),      32'(v.e_ck));
        chk({tag, " busy"},       32'(busy),       32'(v.e_bs));
        chk({tag, " data_valid"}, 32'(data_valid), 32'(v.e_dv));
        chk({tag, " sweep_done"}, 32'(sweep_done), 32'(v.e_sd));
        chk({tag, " err"},        32'(err),        32'(v.e_er));
    endtask

    task automatic run_vecs(input string pfx, input vec_t q[$]);
        foreach (q[i]) begin
            start = q[i].start; stop = q[i].stop; mode = q[i].mode;
            manual_load = q[i].ld; chan_mask = q[i].mask; dwell = q[i].dwell;
            manual_sel = q[i].msel;
            @(posedge clk); #1;
            check_outs($sformatf("%s%0d", pfx, i), q[i]);
        end
        idle_inputs();
    endtask

    initial begin
        // ---- table A: single sweep, continuous sweep, empty mask, stop ----
        // test 1: mask 101, dwell 4, single sweep
        vec_a.push_back(mk(1,0,0,5,4,0,0, 0,1,1,0,0,0));
        vec_a.push_back(mk(0,0,0,5,4,0,0, 0,0,1,0,0,0));
        for (int k = 0; k < 4; k++) vec_a.push_back(mk(0,0,0,5,4,0,0, 0,0,1,1,0,0));
        vec_a.push_back(mk(0,0,0,5,4,0,0, 2,1,1,0,0,0));
        vec_a.push_back(mk(0,0,0,5,4,0,0, 2,0,1,0,0,0));
        for (int k = 0; k < 3; k++) vec_a.push_back(mk(0,0,0,5,4,0,0, 2,0,1,1,0,0));
        vec_a.push_back(mk(0,0,0,5,4,0,0, 2,0,1,1,1,0));
        vec_a.push_back(mk(0,0,0,5,4,0,0, 2,0,0,0,0,0));
        // test 2: mask 111, dwell 0 (=1), continuous; later input changes and start ignored
        vec_a.push_back(mk(1,0,1,7,0,0,0, 0,1,1,0,0,0));
        vec_a.push_back(mk(1,0,0,1,5,0,0, 0,0,1,0,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 0,0,1,1,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 1,1,1,0,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 1,0,1,0,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 1,0,1,1,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 2,1,1,0,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 2,0,1,0,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 2,0,1,1,1,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 0,1,1,0,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 0,0,1,0,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 0,0,1,1,0,0));
        vec_a.push_back(mk(0,0,0,1,5,0,0, 1,1,1,0,0,0));
        vec_a.push_back(mk(0,1,0,1,5,0,0, 1,0,0,0,0,0));
        // test 3: empty mask -> err pulse only
        vec_a.push_back(mk(1,0,0,0,4,0,0, 1,0,0,0,0,1));
        vec_a.push_back(mk(0,0,0,0,4,0,0, 1,0,0,0,0,0));
        // test 4: continuous, dwell 3, stop in the middle of ch1 dwell
        vec_a.push_back(mk(1,0,1,7,3,0,0, 0,1,1,0,0,0));
        vec_a.push_back(mk(0,0,1,7,3,0,0, 0,0,1,0,0,0));
        for (int k = 0; k < 3; k++) vec_a.push_back(mk(0,0,1,7,3,0,0, 0,0,1,1,0,0));
        vec_a.push_back(mk(0,0,1,7,3,0,0, 1,1,1,0,0,0));
        vec_a.push_back(mk(0,0,1,7,3,0,0, 1,0,1,0,0,0));
        vec_a.push_back(mk(0,0,1,7,3,0,0, 1,0,1,1,0,0));
        vec_a.push_back(mk(0,1,1,7,3,0,0, 1,0,0,0,0,0));
        vec_a.push_back(mk(1,1,1,7,3,0,0, 1,0,0,0,0,0));
        vec_a.push_back(mk(1,1,0,0,3,0,0, 1,0,0,0,0,0));
        vec_a.push_back(mk(0,1,0,0,3,0,0, 1,0,0,0,0,0));

        // ---- table B: after reset, manual loads and start/manual_load priority ----
        vec_b.push_back(mk(0,0,0,0,0,1,3, 0,0,0,0,0,0));
        vec_b.push_back(mk(0,0,0,0,0,1,2, 2,1,0,0,0,0));
        vec_b.push_back(mk(0,0,0,0,0,0,0, 2,0,0,0,0,0));
        vec_b.push_back(mk(1,0,0,2,1,1,0, 1,1,1,0,0,0));
        vec_b.push_back(mk(0,0,0,2,1,1,0, 1,0,1,0,0,0));
        vec_b.push_back(mk(0,0,0,2,1,0,0, 1,0,1,1,1,0));
        vec_b.push_back(mk(0,0,0,2,1,0,0, 1,0,0,0,0,0));

        // ---- reset state ----
        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        resetn = 1'b1;

        run_vecs("a", vec_a);

        // ---- asynchronous reset while settling ----
        start = 1; chan_mask = 3'b010; dwell = 16'd2;
        @(posedge clk); #1;
        check_outs("rst_sw", mk(0,0,0,0,0,0,0, 1,1,1,0,0,0));
        idle_inputs();
        @(posedge clk); #1;
        check_outs("rst_settle", mk(0,0,0,0,0,0,0, 1,0,1,0,0,0));
        #2 resetn = 1'b0;
        #1;
        check_outs("rst_async", mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        @(posedge clk); #1;
        check_outs("rst_hold", mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
        resetn = 1'b1;
        @(posedge clk); #1;
        check_outs("rst_after", mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));

        run_vecs("b", vec_b);

`ifdef LATCHED_MUX_SCAN_TAG_EN
        begin
            int mux_ch = -1;
            int pend_due = -1;
            int pend_ch = 0;
            int n_dv = 0;
            int n_sd = 0;
            int cyc = 0;
            chk("tag_reset_hold", 32'(chan_tag), 32'(1));
            start = 1; mode = 1; chan_mask = 3'b111; dwell = 16'd2;
            while (n_sd < 3 && cyc < 60) begin
                @(posedge clk); #1;
                start = 0;
                if (pend_due == cyc) mux_ch = pend_ch;
                if (clken) begin
                    pend_due = cyc + ML;
                    pend_ch  = int'(sel);
                end
                if (data_valid) begin
                    chk($sformatf("tag c%0d mux", cyc), 32'(mux_ch), 32'((n_dv / 2) % 3));
                    chk($sformatf("tag c%0d tag", cyc), 32'(chan_tag), 32'(mux_ch));
                    n_dv++;
                end
                if (sweep_done) n_sd++;
                cyc++;
            end
            chk("tag sweeps", 32'(n_sd), 32'(3));
            chk("tag samples", 32'(n_dv), 32'(18));
            stop = 1;
            @(posedge clk); #1;
            stop = 0;
            chk("tag stop busy", 32'(busy), 32'(0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Absolute bound in case the run stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
